lc3_io_ctrl: RTL and testbench

LC3_IO_CTRL -- requirements
Module: lc3_io_ctrl

---
 rtl/lc3_io_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_lc3_io_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_io_ctrl.sv
// LC-3 memory-mapped I/O: keyboard FIFO (KBSR/KBDR), display handshake (DSR/DDR), machine control (MCR).
// Define LC3_KBD_INT_EN to build the KBSR[14] interrupt-enable bit and the registered kb_irq output.
module lc3_io_ctrl #(
  parameter int unsigned KBD_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_en,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        sel,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        kb_ready,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  input  logic        disp_ack,
  output logic        halt
`ifdef LC3_KBD_INT_EN
  ,
  output logic        kb_irq
`endif
);

  localparam int unsigned AW = (KBD_DEPTH > 1) ? $clog2(KBD_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(KBD_DEPTH);

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;
  localparam logic [15:0] MCR_ADDR  = 16'hFFFE;

  typedef enum logic {
    D_IDLE,
    D_BUSY
  } disp_state_e;

  // Address decode
  logic hit_kbsr, hit_kbdr, hit_dsr, hit_ddr, hit_mcr, hit_any;
  logic wr_kbsr, wr_ddr, wr_mcr, rd_kbdr;

  always_comb begin
    hit_kbsr = (addr == KBSR_ADDR);
    hit_kbdr = (addr == KBDR_ADDR);
    hit_dsr  = (addr == DSR_ADDR);
    hit_ddr  = (addr == DDR_ADDR);
    hit_mcr  = (addr == MCR_ADDR);
    hit_any  = hit_kbsr | hit_kbdr | hit_dsr | hit_ddr | hit_mcr;
    wr_kbsr  = mem_en & we & hit_kbsr;
    wr_ddr   = mem_en & we & hit_ddr;
    wr_mcr   = mem_en & we & hit_mcr;
    rd_kbdr  = mem_en & ~we & hit_kbdr;
  end

  assign sel = mem_en & hit_any;

  // Keyboard receive FIFO
  logic [7:0]    fifo_q [KBD_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          empty, full, push, pop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == FULL_CNT);
    push     = kb_valid & ~full;
    pop      = rd_kbdr & ~empty;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  assign kb_ready = ~full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= kb_data;
    end
  end

  // Display handshake FSM with registered outputs
  disp_state_e disp_state_q;
  logic        disp_valid_q;
  logic [7:0]  disp_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_state_q <= D_IDLE;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
    end else begin
      case (disp_state_q)
        D_IDLE: begin
          if (wr_ddr) begin
            disp_data_q  <= wdata[7:0];
            disp_valid_q <= 1'b1;
            disp_state_q <= D_BUSY;
          end
        end
        D_BUSY: begin
          if (disp_ack) begin
            disp_valid_q <= 1'b0;
            disp_state_q <= D_IDLE;
          end
        end
        default: begin
          disp_valid_q <= 1'b0;
          disp_state_q <= D_IDLE;
        end
      endcase
    end
  end

  assign disp_valid = disp_valid_q;
  assign disp_data  = disp_data_q;

  // Machine control
  logic run_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q <= 1'b1;
    end else if (wr_mcr) begin
      run_q <= wdata[15];
    end
  end

  assign halt = ~run_q;

  // Keyboard interrupt enable
  logic ie;

`ifdef LC3_KBD_INT_EN
  logic ie_q, irq_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr_kbsr) begin
        ie_q <= wdata[14];
      end
      irq_q <= ie_q & ~empty;
    end
  end

  assign ie     = ie_q;
  assign kb_irq = irq_q;

  logic unused_wdata;
  assign unused_wdata = ^wdata[13:8];
`else
  assign ie = 1'b0;

  logic unused_wdata;
  assign unused_wdata = ^{wdata[14:8], wr_kbsr};
`endif

  // Read mux; an empty KBDR reads zero rather than a stale slot
  always_comb begin
    rdata = '0;
    if (hit_kbsr) begin
      rdata = {~empty, ie, 14'b0};
    end else if (hit_kbdr) begin
      rdata = empty ? 16'h0000 : {8'h00, fifo_q[rd_ptr_q]};
    end else if (hit_dsr) begin
      rdata = {(disp_state_q == D_IDLE), 15'b0};
    end else if (hit_ddr) begin
      rdata = {8'h00, disp_data_q};
    end else if (hit_mcr) begin
      rdata = {run_q, 15'b0};
    end
  end

endmodule

// File: tb/tb_lc3_io_ctrl.sv
// Directed self-checking bench for lc3_io_ctrl (KBD_DEPTH=4); interrupt checks built with LC3_KBD_INT_EN.
module tb_lc3_io_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_en;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        sel;
  logic        kb_valid;
  logic [7:0]  kb_data;
  logic        kb_ready;
  logic        disp_valid;
  logic [7:0]  disp_data;
  logic        disp_ack;
  logic        halt;
`ifdef LC3_KBD_INT_EN
  logic        kb_irq;
`endif

  int checks = 0;
  int failures = 0;

  localparam logic [15:0] KBSR = 16'hFE00;
  localparam logic [15:0] KBDR = 16'hFE02;
  localparam logic [15:0] DSR  = 16'hFE04;
  localparam logic [15:0] DDR  = 16'hFE06;
  localparam logic [15:0] MCR  = 16'hFFFE;

  lc3_io_ctrl #(.KBD_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_en     (mem_en),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .sel        (sel),
    .kb_valid   (kb_valid),
    .kb_data    (kb_data),
    .kb_ready   (kb_ready),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .disp_ack   (disp_ack),
    .halt       (halt)
`ifdef LC3_KBD_INT_EN
    ,
    .kb_irq     (kb_irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    mem_en = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    mem_en = 1'b0; we = 1'b0; addr = 16'h0000; wdata = 16'h0000;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [15:0] d, output logic s);
    @(negedge clk);
    mem_en = 1'b1; we = 1'b0; addr = a;
    #1;
    d = rdata;
    s = sel;
    @(negedge clk);
    mem_en = 1'b0; addr = 16'h0000;
  endtask

  task automatic push_char(input logic [7:0] c);
    @(negedge clk);
    kb_valid = 1'b1; kb_data = c;
    @(negedge clk);
    kb_valid = 1'b0; kb_data = 8'h00;
  endtask

  task automatic test_reset;
    logic [15:0] d;
    logic s;
    #2;
    checks++; if (kb_ready !== 1'b1) begin failures++; $display("FAIL rst_kb_ready got=%b exp=1", kb_ready); end
    checks++; if (disp_valid !== 1'b0) begin failures++; $display("FAIL rst_disp_valid got=%b exp=0", disp_valid); end
    checks++; if (halt !== 1'b0) begin failures++; $display("FAIL rst_halt got=%b exp=0", halt); end
`ifdef LC3_KBD_INT_EN
    checks++; if (kb_irq !== 1'b0) begin failures++; $display("FAIL rst_kb_irq got=%b exp=0", kb_irq); end
`endif
    @(negedge clk);
    reset = 1'b0;
    cpu_read(KBSR, d, s);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL rst_kbsr got=%h exp=0000", d); end
    checks++; if (s !== 1'b1) begin failures++; $display("FAIL rst_sel_kbsr got=%b exp=1", s); end
    cpu_read(DSR, d, s);
    checks++; if (d !== 16'h8000) begin failures++; $display("FAIL rst_dsr got=%h exp=8000", d); end
    cpu_read(MCR, d, s);
    checks++; if (d !== 16'h8000) begin failures++; $display("FAIL rst_mcr got=%h exp=8000", d); end
    cpu_read(DDR, d, s);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL rst_ddr got=%h exp=0000", d); end
    cpu_read(16'h3000, d, s);
    checks++; if (d !== 16'h0000 || s !== 1'b0) begin failures++; $display("FAIL miss_read got=%h sel=%b exp=0000 sel=0", d, s); end
  endtask

  task automatic test_kbd_basic;
    logic [15:0] d;
    logic s;
    push_char(8'h41);
    cpu_read(KBSR, d, s);
    checks++; if (d !== 16'h8000) begin failures++; $display("FAIL kb_kbsr_full got=%h exp=8000", d); end
    cpu_read(KBDR, d, s);
    checks++; if (d !== 16'h0041) begin failures++; $display("FAIL kb_kbdr got=%h exp=0041", d); end
    cpu_read(KBSR, d, s);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL kb_kbsr_after got=%h exp=0000", d); end
    cpu_read(KBDR, d, s);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL kb_empty_read got=%h exp=0000", d); end
  endtask

  task automatic test_fifo_full;
    logic [15:0] d;
    logic s;
    for (int unsigned i = 1; i <= 4; i++) begin
      push_char(8'(i));
    end
    checks++; if (kb_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", kb_ready); end
    @(negedge clk);
    kb_valid = 1'b1; kb_data = 8'h05;
    @(negedge clk);
    checks++; if (kb_ready !== 1'b0) begin failures++; $display("FAIL full_held got=%b exp=0", kb_ready); end
    cpu_read(KBDR, d, s);
    checks++; if (d !== 16'h0001) begin failures++; $display("FAIL full_pop1 got=%h exp=0001", d); end
    checks++; if (kb_ready !== 1'b1) begin failures++; $display("FAIL full_room got=%b exp=1", kb_ready); end
    @(negedge clk);
    kb_valid = 1'b0; kb_data = 8'h00;
    checks++; if (kb_ready !== 1'b0) begin failures++; $display("FAIL full_fifth_in got=%b exp=0", kb_ready); end
    for (int unsigned i = 2; i <= 5; i++) begin
      cpu_read(KBDR, d, s);
      checks++; if (d !== 16'(i)) begin failures++; $display("FAIL full_order%0d got=%h exp=%h", i, d, 16'(i)); end
    end
    cpu_read(KBSR, d, s);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL full_drained got=%h exp=0000", d); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] d;
    logic s;
    push_char(8'h10);
    @(negedge clk);
    kb_valid = 1'b1; kb_data = 8'h11;
    mem_en = 1'b1; we = 1'b0; addr = KBDR;
    #1;
    checks++; if (rdata !== 16'h0010) begin failures++; $display("FAIL b2b_pop got=%h exp=0010", rdata); end
    @(negedge clk);
    kb_valid = 1'b0; mem_en = 1'b0; addr = 16'h0000;
    cpu_read(KBDR, d, s);
    checks++; if (d !== 16'h0011) begin failures++; $display("FAIL b2b_next got=%h exp=0011", d); end
    cpu_read(KBSR, d, s);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL b2b_empty got=%h exp=0000", d); end
  endtask

  task automatic test_display;
    logic [15:0] d;
    logic s;
    cpu_write(DDR, 16'h0048);
    for (int unsigned i = 0; i < 3; i++) begin
      checks++; if (disp_valid !== 1'b1 || disp_data !== 8'h48) begin failures++; $display("FAIL disp_busy%0d got=%b/%h exp=1/48", i, disp_valid, disp_data); end
      cpu_read(DSR, d, s);
      checks++; if (d !== 16'h0000) begin failures++; $display("FAIL disp_dsr_busy%0d got=%h exp=0000", i, d); end
    end
    cpu_write(DDR, 16'h0049);
    checks++; if (disp_data !== 8'h48) begin failures++; $display("FAIL disp_ignore_wr got=%h exp=48", disp_data); end
    disp_ack = 1'b1;
    @(negedge clk);
    disp_ack = 1'b0;
    checks++; if (disp_valid !== 1'b0) begin failures++; $display("FAIL disp_ack_valid got=%b exp=0", disp_valid); end
    cpu_read(DSR, d, s);
    checks++; if (d !== 16'h8000) begin failures++; $display("FAIL disp_dsr_idle got=%h exp=8000", d); end
    disp_ack = 1'b1;
    @(negedge clk);
    disp_ack = 1'b0;
    checks++; if (disp_valid !== 1'b0) begin failures++; $display("FAIL disp_idle_ack got=%b exp=0", disp_valid); end
    cpu_write(DDR, 16'h004A);
    checks++; if (disp_valid !== 1'b1 || disp_data !== 8'h4A) begin failures++; $display("FAIL disp_second got=%b/%h exp=1/4a", disp_valid, disp_data); end
    disp_ack = 1'b1;
    @(negedge clk);
    disp_ack = 1'b0;
  endtask

  task automatic test_halt;
    logic [15:0] d;
    logic s;
    cpu_write(MCR, 16'h0000);
    checks++; if (halt !== 1'b1) begin failures++; $display("FAIL halt_set got=%b exp=1", halt); end
    cpu_read(MCR, d, s);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL halt_mcr got=%h exp=0000", d); end
    push_char(8'h7E);
    cpu_read(KBDR, d, s);
    checks++; if (d !== 16'h007E) begin failures++; $display("FAIL halt_kbd got=%h exp=007e", d); end
    checks++; if (halt !== 1'b1) begin failures++; $display("FAIL halt_persist got=%b exp=1", halt); end
    cpu_write(MCR, 16'h8000);
    checks++; if (halt !== 1'b0) begin failures++; $display("FAIL halt_clear got=%b exp=0", halt); end
  endtask

  task automatic test_reset_busy;
    logic [15:0] d;
    logic s;
    cpu_write(MCR, 16'h0000);
    cpu_write(DDR, 16'h0055);
    push_char(8'h01);
    push_char(8'h02);
    checks++; if (disp_valid !== 1'b1 || halt !== 1'b1) begin failures++; $display("FAIL rb_pre got=%b/%b exp=1/1", disp_valid, halt); end
    @(negedge clk);
    #1;
    reset = 1'b1;
    mem_en = 1'b1; we = 1'b0; addr = KBSR;
    #1;
    checks++; if (disp_valid !== 1'b0) begin failures++; $display("FAIL rb_disp_valid got=%b exp=0", disp_valid); end
    checks++; if (rdata !== 16'h0000) begin failures++; $display("FAIL rb_kbsr got=%h exp=0000", rdata); end
    checks++; if (halt !== 1'b0) begin failures++; $display("FAIL rb_halt got=%b exp=0", halt); end
    checks++; if (disp_data !== 8'h00 || kb_ready !== 1'b1) begin failures++; $display("FAIL rb_misc got=%h/%b exp=00/1", disp_data, kb_ready); end
    mem_en = 1'b0; addr = 16'h0000;
    @(negedge clk);
    reset = 1'b0;
    cpu_read(KBDR, d, s);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL rb_kbdr got=%h exp=0000", d); end
  endtask

  task automatic test_irq;
    logic [15:0] d;
    logic s;
    cpu_write(KBSR, 16'h4000);
`ifdef LC3_KBD_INT_EN
    cpu_read(KBSR, d, s);
    checks++; if (d !== 16'h4000) begin failures++; $display("FAIL irq_ie got=%h exp=4000", d); end
    push_char(8'h0D);
    checks++; if (kb_irq !== 1'b0) begin failures++; $display("FAIL irq_early got=%b exp=0", kb_irq); end
    @(negedge clk);
    checks++; if (kb_irq !== 1'b1) begin failures++; $display("FAIL irq_set got=%b exp=1", kb_irq); end
    cpu_read(KBDR, d, s);
    checks++; if (d !== 16'h000D) begin failures++; $display("FAIL irq_pop got=%h exp=000d", d); end
    @(negedge clk);
    checks++; if (kb_irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", kb_irq); end
`else
    cpu_read(KBSR, d, s);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL ie_absent got=%h exp=0000", d); end
`endif
  endtask

  initial begin
    reset = 1'b1;
    mem_en = 1'b0; we = 1'b0; addr = 16'h0000; wdata = 16'h0000;
    kb_valid = 1'b0; kb_data = 8'h00; disp_ack = 1'b0;
    test_reset;
    test_kbd_basic;
    test_fifo_full;
    test_back_to_back;
    test_display;
    test_halt;
    test_reset_busy;
    test_irq;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
